alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides. Single-cycle ops
// complete at the accept edge; MUL runs an iterative shift-add over WIDTH cycles.
module alu_seq #(
    parameter int WIDTH  = 21,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       AluControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] AluResult,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SRA, OP_XOR,
        OP_NOR, OP_SLT, OP_SLTU, OP_MUL
    } op_t;

    localparam bit                     MUL_ON  = (MUL_EN != 0);
    localparam int                     CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]          LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]       WIDTH_V = WIDTH'(WIDTH);

    state_t             state, next_state;
    logic [WIDTH:0]     sum, dif;
    logic               big_shift;
    logic               is_mul;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_ill;
    logic [2*WIDTH-1:0] mcand, prod, prod_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      mcnt;

    assign is_mul    = MUL_ON && (AluControl == OP_MUL);
    assign sum       = {1'b0, A} + {1'b0, B};
    assign dif       = {1'b0, A} - {1'b0, B};
    assign big_shift = (B >= WIDTH_V);
    assign prod_next = prod + (mplier[0] ? mcand : '0);
    assign Zero      = (AluResult == '0);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (AluControl)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SLL:  alu_res = big_shift ? '0 : (A << B);
            OP_SRL:  alu_res = big_shift ? '0 : (A >> B);
            OP_SRA:  alu_res = big_shift ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> B);
            OP_SLT:  alu_res[0] = ($signed(A) < $signed(B));
            OP_SLTU: alu_res[0] = (A < B);
            OP_MUL:  alu_ill = !MUL_ON;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = is_mul ? MUL : DONE;
            end
            MUL:  if (mcnt == LAST) next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result and flags only change at acceptance or on the final MUL step,
    // so they hold steady for the whole DONE phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            AluResult <= '0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
            mcnt      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (is_mul) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        prod   <= '0;
                        mcnt   <= '0;
                    end else begin
                        AluResult <= alu_res;
                        Carry     <= alu_c;
                        Overflow  <= alu_v;
                        Illegal   <= alu_ill;
                    end
                end
                MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mcnt   <= mcnt + CW'(1);
                    if (mcnt == LAST) begin
                        AluResult <= prod_next[WIDTH-1:0];
                        Carry     <= |prod_next[2*WIDTH-1:WIDTH];
                        Overflow  <= 1'b0;
                        Illegal   <= 1'b0;
                        mcnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an arithmetic reference model tracks handshakes and expected
// results; one negedge process compares every cycle, plus directed literal cases.
module tb_alu_seq;

    localparam int W = 21;
    localparam longint unsigned MASK = (64'd1 << W) - 1;
    localparam longint MAXS = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINS = -(64'sd1 <<< (W - 1));

    typedef struct packed {
        logic           ill;
        logic           ovf;
        logic           car;
        logic [W-1:0]   res;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, AluResult;
    logic [3:0]   AluControl;
    logic         Zero, Carry, Overflow, Illegal;

    int   n_chk = 0;
    int   n_fail = 0;
    int   e = 0, e0 = 0, lat = 1;
    bit   busy = 1'b0, started = 1'b0, rst_clean = 1'b0;
    exp_t ex;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .AluControl(AluControl), .out_valid(out_valid),
        .out_ready(out_ready), .AluResult(AluResult), .Zero(Zero),
        .Carry(Carry), .Overflow(Overflow), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exv, $time);
        end
    endtask

    function automatic longint sgn(input longint unsigned x);
        if (((x >> (W - 1)) & 1) != 0) return longint'(x) - (64'sd1 <<< W);
        return longint'(x);
    endfunction

    function automatic exp_t model(input logic [3:0] op, input longint unsigned a, input longint unsigned b);
        longint unsigned r = 0, p;
        longint          sa = sgn(a), sb = sgn(b), s;
        bit              c = 0, v = 0, il = 0;
        exp_t            m;
        case (op)
            0:  begin p = a + b; r = p & MASK; c = (p >> W) != 0; s = sa + sb; v = (s > MAXS) || (s < MINS); end
            1:  begin r = (a - b) & MASK; c = a < b; s = sa - sb; v = (s > MAXS) || (s < MINS); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = (b >= W) ? 0 : ((a << b) & MASK);
            5:  r = (b >= W) ? 0 : (a >> b);
            6:  r = (b >= W) ? ((sa < 0) ? MASK : 0) : (longint'(sa >>> b) & MASK);
            7:  r = a ^ b;
            8:  r = ~(a | b) & MASK;
            9:  r = (sa < sb) ? 1 : 0;
            10: r = (a < b) ? 1 : 0;
            11: begin p = a * b; r = p & MASK; c = (p >> W) != 0; end
            default: il = 1;
        endcase
        m.ill = il; m.ovf = v; m.car = c; m.res = W'(r);
        return m;
    endfunction

    // Reference transaction model: one op in flight, results valid lat-1 edges after accept.
    always @(posedge clk) begin
        e++;
        if (reset) begin
            busy = 1'b0; started = 1'b1; rst_clean = 1'b1;
        end else if (started) begin
            if (busy && (e - 1 - e0 >= lat - 1) && out_ready) begin
                busy = 1'b0;
            end else if (!busy && in_valid) begin
                busy = 1'b1; e0 = e; rst_clean = 1'b0;
                lat = (AluControl == 4'd11) ? W + 1 : 1;
                ex = model(AluControl, A, B);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit vexp;
            vexp = busy && (e - e0 >= lat - 1);
            chk("out_valid", out_valid, vexp);
            chk("in_ready", in_ready, !busy);
            if (vexp) begin
                chk("result", AluResult, ex.res);
                chk("zero", Zero, ex.res == '0);
                chk("carry", Carry, ex.car);
                chk("overflow", Overflow, ex.ovf);
                chk("illegal", Illegal, ex.ill);
            end else if (rst_clean) begin
                chk("rst_result", AluResult, 0);
                chk("rst_zero", Zero, 1);
                chk("rst_flags", {Carry, Overflow, Illegal}, 0);
            end
        end
    end

    task automatic pin(input string name, input logic [3:0] op, input longint unsigned a,
                       input longint unsigned b, input longint unsigned r, input bit c,
                       input bit v, input bit il);
        exp_t m;
        m = model(op, a, b);
        chk({name, "_res"}, m.res, r);
        chk({name, "_flags"}, {m.car, m.ovf, m.ill}, {c, v, il});
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold, input longint unsigned r,
                          input bit c, input bit v, input bit il, input int elat);
        int n = 0;
        int l = 1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        in_valid = 1'b1; A = a; B = b; AluControl = op;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && l < W + 10) begin @(negedge clk); l++; end
        chk({name, "_latency"}, l, elat);
        chk({name, "_res"}, AluResult, r);
        chk({name, "_flags"}, {Zero, Carry, Overflow, Illegal}, {r == 0, c, v, il});
        repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold_ready"}, in_ready, 0);
        end
        chk({name, "_hold_res"}, AluResult, r);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; AluControl = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        pin("m_add", 0, 'h1FFFFF, 1, 0, 1, 0, 0);
        pin("m_sub", 1, 5, 7, 'h1FFFFE, 1, 0, 0);
        pin("m_subovf", 1, 'h0FFFFF, 'h100000, 'h1FFFFF, 1, 1, 0);
        pin("m_sll", 4, 1, 25, 0, 0, 0, 0);
        pin("m_sra4", 6, 'h100000, 4, 'h1F0000, 0, 0, 0);
        pin("m_sra30", 6, 'h100000, 30, 'h1FFFFF, 0, 0, 0);
        pin("m_mul", 11, 1000, 1000, 'h0F4240, 0, 0, 0);
        pin("m_mulov", 11, 'h1000, 'h1000, 0, 1, 0, 0);
        pin("m_ill", 13, 3, 4, 0, 0, 0, 1);

        run_op("add", 0, 'h1FFFFF, 1, 0, 0, 1, 0, 0, 1);
        run_op("sub", 1, 5, 7, 0, 'h1FFFFE, 1, 0, 0, 1);
        run_op("subovf", 1, 'h0FFFFF, 'h100000, 0, 'h1FFFFF, 1, 1, 0, 1);
        run_op("sll", 4, 1, 25, 0, 0, 0, 0, 0, 1);
        run_op("sra4", 6, 'h100000, 4, 0, 'h1F0000, 0, 0, 0, 1);
        run_op("sra30", 6, 'h100000, 30, 5, 'h1FFFFF, 0, 0, 0, 1);
        run_op("mul", 11, 1000, 1000, 0, 'h0F4240, 0, 0, 0, W + 1);
        run_op("mulov", 11, 'h1000, 'h1000, 5, 0, 1, 0, 0, W + 1);

        in_valid = 1'b1; A = 'd77; B = 'd99; AluControl = 4'd11;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_res", AluResult, 0);
        run_op("illegal", 13, 'h12345, 'h54321, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            AluControl = 4'($urandom_range(0, 15));
            A          = W'($urandom);
            B          = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) A = W'($urandom_range(0, 2047));
            @(negedge clk);
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
